corevx_tlb_assoc: RTL
=====================

Name: corevx_tlb_assoc

Overview:
- Parametrised set-associative successor to the direct-mapped corevx_tlb.
- Translates virtual page numbers (VPN) to physical page numbers (PPN) with per-entry 8-bit access tags.
- Registered one-cycle resolve.
- Configurable sets and ways, round-robin replacement per set, whole-TLB and single-VPN invalidation.
- Sits between the MMU page-table walker (writes) and the fetch/load-store address path (resolves).

Parameters:
- VIRT_W, 20, VPN width.
- PHYS_W, 22, PPN width; must be >= VIRT_W.
- SETS_W, 6, log2 of set count; set index = VPN[SETS_W-1:0].
- WAYS, 2, associativity; legal values 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = translate; 0 = bypass.
- resolve  in  1  lookup request, sampled every cycle.
- virtual_address  in  VIRT_W  lookup VPN.
- done  out  1  lookup result valid, one-cycle pulse per accepted resolve.
- miss  out  1  lookup missed; valid only while done=1.
- accesstag_r  out  8  tag of the hit entry.
- phys_r  out  PHYS_W  PPN of the hit entry.
- write  in  1  install entry.
- invalidate_one  in  1  clear entries matching virtual_address_w.
- virtual_address_w  in  VIRT_W  VPN for write / invalidate_one.
- phys_w  in  PHYS_W  PPN to install.
- accesstag_w  in  8  tag to install, stored verbatim.
- invalidate  in  1  clear all entries.

Behaviour:
- Reset, asynchronous on rst_n low, deassertion synchronous to clk:
  - All valid bits cleared; all round-robin pointers = 0.
  - done=0, miss=0, accesstag_r=0, phys_r=0.
  - Tag and data arrays need no reset.
  - Reset mid-lookup drops the pending result; no done follows.
- Resolve, latency 1:
  - resolve=1 sampled at edge N → done=1 during cycle N+1.
  - resolve held high gives done on every following cycle.
  - resolve=0 at edge N → done=0 in cycle N+1.
  - miss, accesstag_r and phys_r hold their last values while done=0.
- enable=0 at the resolve edge: done=1, miss=0, phys_r = zero-extended virtual_address, accesstag_r=0. TLB contents are not consulted.
- enable=1: hit when any way in the indexed set is valid and its stored VPN equals virtual_address.
  - Hit: miss=0, outputs take that way's data.
  - No hit: miss=1, accesstag_r=0, phys_r=0.
  - Multiple hits cannot occur; write guarantees no duplicates.
- Write, takes effect at the edge:
  - Victim selection, in order:
    1. The way already holding virtual_address_w (overwrite in place).
    2. Else the lowest-numbered invalid way.
    3. Else the way given by the set's round-robin pointer; the pointer then advances modulo WAYS.
  - The pointer changes only in case 3.
- invalidate_one: at the edge, clears the valid bit of any way in the indexed set whose VPN matches virtual_address_w. Pointer unchanged.
- invalidate: at the edge, clears all valid bits and resets all pointers to 0.
- Same-edge priority: invalidate > invalidate_one > write.
  - Lower-priority maintenance ops in the same cycle are discarded.
- resolve in the same cycle as maintenance: the lookup uses pre-edge contents, i.e. read-before-write. A resolve coincident with a write of the same VPN misses if the VPN was not previously present.
- WAYS=1 reduces to direct-mapped; the pointer is unused.

Optional Feature:
- Macro: CORE_TLB_ASID_EN.
- Defined:
  - Adds parameter ASID_W (default 9) and input ports asid (ASID_W), lookup ASID, and asid_w (ASID_W), install ASID.
  - Each entry stores asid_w.
  - A hit additionally requires stored ASID == asid, unless the stored accesstag bit 5 (global) is 1.
  - Write in-place match (victim rule 1) compares VPN and ASID.
  - invalidate_one still ignores ASID.
- Undefined: no ASID ports or storage; matching is on VPN only.

Test Plan:
- Reset, then enable=0, resolve=1 with VA 20'h0_0123 → next cycle done=1, miss=0, phys_r=22'h0_0123, accesstag_r=0. Drop resolve → done=0 next cycle.
- After reset, enable=1, resolve VA 20'h2_0000 → done=1, miss=1. Write 20'h2_0000→22'h1_0000, tag 8'hB1 → resolve gives miss=0, phys_r=22'h1_0000, accesstag_r=8'hB1.
- Writes to set 0: 20'h2_0000→1_0000, then 20'h2_0040→1_0040 (fills way1), then 20'h2_0080→1_0080. Required: third write evicts way0. Resolves give 2_0000 miss, 2_0040 hit 1_0040, 2_0080 hit 1_0080. A fourth write 20'h2_00C0 evicts way1 (2_0040 now misses).
- Rewrite 20'h2_0040 with phys 22'h3_0040, tag 8'hB3 → hit returns the new values. Entry not duplicated; the other way's entry in set 0 is still present.
- Hold resolve on 20'h2_0040 while pulsing invalidate_one with virtual_address_w=20'h2_0040 → same-cycle lookup hits, next lookup misses; other set-0 way still hits. Then invalidate=1 together with write=1 → write discarded; every resolve misses.
- Assert rst_n low mid-resolve → done, miss, outputs 0 immediately; previously written VPN misses after reset release.

Source files
------------

// File: rtl/corevx_tlb_assoc.sv
// Set-associative VPN->PPN translation buffer: one-cycle registered resolve, round-robin refill,
// whole-TLB and single-VPN invalidation. Define CORE_TLB_ASID_EN to add per-entry ASID matching.
module corevx_tlb_assoc #(
   parameter int VIRT_W = 20,
   parameter int PHYS_W = 22,
   parameter int SETS_W = 6,
   parameter int WAYS   = 2
`ifdef CORE_TLB_ASID_EN
   ,
   parameter int ASID_W = 9
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              resolve,
   input  logic [VIRT_W-1:0] virtual_address,
   output logic              done,
   output logic              miss,
   output logic [7:0]        accesstag_r,
   output logic [PHYS_W-1:0] phys_r,
   input  logic              write,
   input  logic              invalidate_one,
   input  logic [VIRT_W-1:0] virtual_address_w,
   input  logic [PHYS_W-1:0] phys_w,
   input  logic [7:0]        accesstag_w,
`ifdef CORE_TLB_ASID_EN
   input  logic [ASID_W-1:0] asid,
   input  logic [ASID_W-1:0] asid_w,
`endif
   input  logic              invalidate
);

   localparam int SETS  = 1 << SETS_W;
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [PTR_W-1:0] LAST_WAY = PTR_W'(WAYS - 1);

   logic [VIRT_W-1:0] vpn_mem  [SETS][WAYS];
   logic [PHYS_W-1:0] phys_mem [SETS][WAYS];
   logic [7:0]        tag_mem  [SETS][WAYS];
   logic [WAYS-1:0]   valid_q  [SETS];
   logic [PTR_W-1:0]  rr_q     [SETS];

   logic [SETS_W-1:0] rset, wset;
   assign rset = virtual_address[SETS_W-1:0];
   assign wset = virtual_address_w[SETS_W-1:0];

   logic [WAYS-1:0] r_asid_ok, w_asid_ok;
`ifdef CORE_TLB_ASID_EN
   logic [ASID_W-1:0] asid_mem [SETS][WAYS];
   always_comb begin
      r_asid_ok = '0;
      w_asid_ok = '0;
      for (int w = 0; w < WAYS; w++) begin
         // Bit 5 of the access tag marks a global mapping shared by all address spaces.
         r_asid_ok[w] = tag_mem[rset][w][5] || (asid_mem[rset][w] == asid);
         w_asid_ok[w] = (asid_mem[wset][w] == asid_w);
      end
   end
`else
   assign r_asid_ok = '1;
   assign w_asid_ok = '1;
`endif

   // Lookup against pre-edge contents, so a coincident maintenance op never affects this resolve.
   logic              hit;
   logic [PHYS_W-1:0] hit_phys;
   logic [7:0]        hit_tag;
   always_comb begin
      hit      = 1'b0;
      hit_phys = '0;
      hit_tag  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[rset][w] && (vpn_mem[rset][w] == virtual_address) && r_asid_ok[w]) begin
            hit      = 1'b1;
            hit_phys = phys_mem[rset][w];
            hit_tag  = tag_mem[rset][w];
         end
      end
   end

   logic [WAYS-1:0]  inv_match;
   logic             same_hit, free_hit, use_rr;
   logic [PTR_W-1:0] same_way, free_way, victim;
   always_comb begin
      inv_match = '0;
      same_hit  = 1'b0;
      same_way  = '0;
      free_hit  = 1'b0;
      free_way  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[wset][w] && (vpn_mem[wset][w] == virtual_address_w)) begin
            inv_match[w] = 1'b1;
            if (w_asid_ok[w]) begin
               same_hit = 1'b1;
               same_way = PTR_W'(w);
            end
         end
      end
      // Descending scan so the lowest-numbered free way is the one left selected.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[wset][w]) begin
            free_hit = 1'b1;
            free_way = PTR_W'(w);
         end
      end
      use_rr = !same_hit && !free_hit;
      victim = same_hit ? same_way : (free_hit ? free_way : rr_q[wset]);
   end

   logic do_write;
   assign do_write = write && !invalidate && !invalidate_one;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (invalidate) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (invalidate_one) begin
         valid_q[wset] <= valid_q[wset] & ~inv_match;
      end else if (write) begin
         valid_q[wset][victim] <= 1'b1;
         if (use_rr && (WAYS > 1)) begin
            rr_q[wset] <= (rr_q[wset] == LAST_WAY) ? '0 : rr_q[wset] + PTR_W'(1);
         end
      end
   end

   // NOTE: the entry payload arrays are deliberately left without reset; the valid bits alone
   // decide whether an entry can match, and a reset here would turn the storage into flops.
   always_ff @(posedge clk) begin
      if (do_write) begin
         vpn_mem[wset][victim]  <= virtual_address_w;
         phys_mem[wset][victim] <= phys_w;
         tag_mem[wset][victim]  <= accesstag_w;
`ifdef CORE_TLB_ASID_EN
         asid_mem[wset][victim] <= asid_w;
`endif
      end
   end

   // NOTE: all state updates use non-blocking assignment so every block sees pre-edge values,
   // which is exactly what gives the read-before-write lookup behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done        <= 1'b0;
         miss        <= 1'b0;
         accesstag_r <= '0;
         phys_r      <= '0;
      end else begin
         done <= resolve;
         if (resolve) begin
            if (!enable) begin
               miss        <= 1'b0;
               accesstag_r <= '0;
               phys_r      <= PHYS_W'(virtual_address);
            end else begin
               miss        <= !hit;
               accesstag_r <= hit_tag;
               phys_r      <= hit_phys;
            end
         end
      end
   end

endmodule
